// File: rtl/rs232_rx_module.sv
// rtl/rs232_rx_module.sv - RS232 8N1 receiver with a first-word-fall-through byte FIFO
//
// Purpose:
//   Receives serial bytes (LSB first) from an asynchronous header pin.
//   Queues the good bytes for the command parser.
//   The optional macro RS232_RX_PARITY_EN adds an even-parity bit after bit 7,
//   which gives an 11-bit frame.
//
// Ports:
//   clk        in   system clock; all logic runs on the rising edge
//   reset_n    in   asynchronous active-low reset
//   rx         in   raw serial line; asynchronous, idle high
//   rd_req     in   pop the FIFO head; ignored while the FIFO is empty
//   clear_err  in   synchronous clear of the sticky overflow flag
//   rx_data    out  FIFO head byte; valid while rx_empty=0
//   rx_empty   out  FIFO empty
//   rx_full    out  FIFO full
//   rx_count   out  number of bytes in the FIFO
//   frame_err  out  one-cycle pulse on a bad stop bit (or bad parity)
//   overflow   out  sticky flag; set when a byte is dropped on a full FIFO
//   busy       out  high while the receiver is not idle

module rs232_rx_module #(
   parameter int CLK_HZ          = 50000000,
   parameter int BAUD            = 115200,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       rx,
   input  logic                       rd_req,
   input  logic                       clear_err,
   output logic [7:0]                 rx_data,
   output logic                       rx_empty,
   output logic                       rx_full,
   output logic [FIFO_DEPTH_LOG2:0]   rx_count,
   output logic                       frame_err,
   output logic                       overflow,
   output logic                       busy
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int NW    = FIFO_DEPTH_LOG2 + 1;

   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

`ifdef RS232_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH, S_PARITY
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
   } state_t;
`endif

   state_t          state;
   logic            rx_m;
   logic            rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            wr_en;
`ifdef RS232_RX_PARITY_EN
   logic            par_err;
`endif

   // The synchronizer and the receive FSM share one block.
   // shift stays stable after the stop-bit sample until the next frame's
   // data bits arrive, so the FIFO can take its write data straight from shift.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         wr_en     <= 1'b0;
         frame_err <= 1'b0;
`ifdef RS232_RX_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         rx_m      <= rx;
         rx_s      <= rx_m;
         wr_en     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state <= S_START;
                  cnt   <= '0;
               end
            end
            S_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  // A line that is already high again at mid-start was only a glitch.
                  state   <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == DIV_LAST) begin
                  cnt            <= '0;
                  shift[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef RS232_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == DIV_LAST) begin
                  cnt     <= '0;
                  // With even parity, the data bits plus the parity bit hold an even number of ones.
                  par_err <= ^{shift, rx_s};
                  state   <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= S_IDLE;
`ifdef RS232_RX_PARITY_EN
                     if (par_err) frame_err <= 1'b1;
                     else         wr_en     <= 1'b1;
`else
                     wr_en <= 1'b1;
`endif
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               // Hold here through a break so that it does not read as a stream of 0x00 bytes.
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [NW-1:0]              count;
   logic                       full;
   logic                       do_rd;
   logic                       do_wr;

   assign full  = (count == FULL_CNT);
   assign do_rd = rd_req && (count != '0);
   // A read in the same cycle frees a slot, so a write on a full FIFO is still accepted.
   assign do_wr = wr_en && (!full || do_rd);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= shift;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A new drop takes priority over a clear in the same cycle.
         if (wr_en && full && !do_rd) overflow <= 1'b1;
         else if (clear_err)          overflow <= 1'b0;
      end
   end

   assign rx_data  = mem[rd_ptr];
   assign rx_empty = (count == '0);
   assign rx_full  = full;
   assign rx_count = count;

endmodule

// File: tb/tb_rs232_rx_module.sv
// tb/tb_rs232_rx_module.sv - self-checking bench for rs232_rx_module

module tb_rs232_rx_module;

   localparam int CLK_HZ = 1000000;
   localparam int BAUD   = 62500;
   localparam int DIV    = CLK_HZ / BAUD;
   localparam int HALF   = DIV / 2;
   localparam int LOG2   = 4;
   localparam int DEPTH  = 1 << LOG2;
`ifdef RS232_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   // 2 synchronizer cycles, half a start bit, the remaining data/parity/stop bits, then write and count update
   localparam int LAT = 2 + HALF + (9 + PB) * DIV + 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          rx = 1'b1;
   logic          rd_req = 1'b0;
   logic          clear_err = 1'b0;
   logic [7:0]    rx_data;
   logic          rx_empty;
   logic          rx_full;
   logic [LOG2:0] rx_count;
   logic          frame_err;
   logic          overflow;
   logic          busy;

   rs232_rx_module #(
      .CLK_HZ(CLK_HZ),
      .BAUD(BAUD),
      .FIFO_DEPTH_LOG2(LOG2)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .rx(rx),
      .rd_req(rd_req),
      .clear_err(clear_err),
      .rx_data(rx_data),
      .rx_empty(rx_empty),
      .rx_full(rx_full),
      .rx_count(rx_count),
      .frame_err(frame_err),
      .overflow(overflow),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int fe_cnt = 0;
`ifdef RS232_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish, passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one frame from the next cycle on. rx is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      cycles(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cycles(DIV);
      end
`ifdef RS232_RX_PARITY_EN
      rx = (^d) ^ par_flip;
      cycles(DIV);
`endif
      rx = stop;
      cycles(DIV);
   endtask

   task automatic pop();
      rd_req = 1'b1;
      cycles(1);
      rd_req = 1'b0;
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       ok;
   } vec_t;

   vec_t       vt [6];
   logic [7:0] q [$];
   logic       ovf_m;
   int         lat;
   int         fe0;
   logic [7:0] b;

   initial begin
      vt[0] = '{8'hA5, 1'b0, 1'b0};
      vt[1] = '{8'h3C, 1'b1, 1'b1};
      vt[2] = '{8'hFF, 1'b1, 1'b1};
      vt[3] = '{8'h00, 1'b1, 1'b1};
      vt[4] = '{8'h80, 1'b0, 1'b0};
      vt[5] = '{8'h5A, 1'b1, 1'b1};

      cycles(3);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_empty", rx_empty, 1);
      check("reset_rx_full", rx_full, 0);
      check("reset_rx_count", rx_count, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_overflow", overflow, 0);
      check("reset_busy", busy, 0);
      reset_n = 1'b1;
      cycles(3);

      // First byte, with its latency measured from the falling edge of the start bit
      lat = -1;
      fork
         send_frame(8'h21, 1'b1);
         begin
            for (int i = 1; i <= LAT + 20; i++) begin
               @(negedge clk);
               if (rx_empty === 1'b0 && lat < 0) lat = i - 1;
            end
         end
      join
      check("first_byte_latency", lat, LAT);
      check("first_byte_data", rx_data, 8'h21);
      check("first_byte_count", rx_count, 1);
      pop();
      check("pop_empty", rx_empty, 1);
      check("pop_count", rx_count, 0);

      // Glitch shorter than half a bit
      fe0 = fe_cnt;
      rx = 1'b0;
      cycles(4);
      check("glitch_busy_during", busy, 1);
      rx = 1'b1;
      cycles(HALF + 6);
      check("glitch_busy_after", busy, 0);
      check("glitch_empty", rx_empty, 1);
      check("glitch_no_frame_err", fe_cnt - fe0, 0);

      // Table of good and bad-stop frames
      for (int k = 0; k < 6; k++) begin
         fe0 = fe_cnt;
         send_frame(vt[k].d, vt[k].stop);
         if (!vt[k].stop) begin
            cycles(10 * DIV);
            check("break_busy_held", busy, 1);
            check("break_no_bytes", rx_count, 0);
            rx = 1'b1;
         end
         cycles(4);
         check("vec_frame_err_pulses", fe_cnt - fe0, vt[k].ok ? 0 : 1);
         check("vec_busy_idle", busy, 0);
         check("vec_count", rx_count, vt[k].ok ? 1 : 0);
         if (vt[k].ok) begin
            check("vec_data", rx_data, vt[k].d);
            pop();
         end
      end

      // Overflow and ordering: 17 bytes, no reads
      ovf_m = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         send_frame(8'(i), 1'b1);
         if (q.size() < DEPTH) q.push_back(8'(i));
         else ovf_m = 1'b1;
      end
      cycles(2);
      check("ovf_full", rx_full, 1);
      check("ovf_count", rx_count, DEPTH);
      check("ovf_flag", overflow, ovf_m);
      while (q.size() > 0) begin
         b = q.pop_front();
         check("ovf_order", rx_data, b);
         pop();
      end
      check("ovf_drained", rx_empty, 1);
      clear_err = 1'b1;
      cycles(1);
      clear_err = 1'b0;
      check("ovf_cleared", overflow, 0);

      // Write into a full FIFO in the same cycle as a read
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'h40 + 8'(i), 1'b1);
         q.push_back(8'h40 + 8'(i));
      end
      fork
         send_frame(8'h99, 1'b1);
         begin
            repeat (LAT) @(negedge clk);
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
         end
      join
      void'(q.pop_front());
      q.push_back(8'h99);
      cycles(2);
      check("simul_count", rx_count, DEPTH);
      check("simul_no_overflow", overflow, 0);
      while (q.size() > 0) begin
         b = q.pop_front();
         check("simul_order", rx_data, b);
         pop();
      end

      // Random sends and reads against the queue model
      ovf_m = 1'b0;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 3) != 0) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            cycles(2);
            if (q.size() < DEPTH) q.push_back(b);
            else ovf_m = 1'b1;
         end else begin
            if (q.size() > 0) begin
               b = q.pop_front();
               check("rand_head", rx_data, b);
            end
            pop();
         end
         check("rand_count", rx_count, q.size());
         check("rand_overflow", overflow, ovf_m);
      end
      clear_err = 1'b1;
      cycles(1);
      clear_err = 1'b0;
      while (q.size() > 0) begin
         b = q.pop_front();
         check("rand_drain", rx_data, b);
         pop();
      end
      check("rand_empty", rx_empty, 1);

      // Reset during bit 4 discards the partial byte and the queued one
      send_frame(8'h11, 1'b1);
      cycles(2);
      rx = 1'b0;
      cycles(DIV);
      for (int i = 0; i < 4; i++) begin
         rx = 8'h55 >> i;
         cycles(DIV);
      end
      rx = 1'b1;
      cycles(DIV / 2);
      reset_n = 1'b0;
      cycles(2);
      rx = 1'b1;
      reset_n = 1'b1;
      cycles(4);
      check("rst_mid_count", rx_count, 0);
      check("rst_mid_busy", busy, 0);
      send_frame(8'h7E, 1'b1);
      cycles(4);
      check("rst_after_count", rx_count, 1);
      check("rst_after_data", rx_data, 8'h7E);
      pop();

`ifdef RS232_RX_PARITY_EN
      fe0 = fe_cnt;
      send_frame(8'h07, 1'b1);
      cycles(4);
      check("par_good_count", rx_count, 1);
      check("par_good_data", rx_data, 8'h07);
      pop();
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      par_flip = 1'b0;
      cycles(4);
      check("par_bad_count", rx_count, 0);
      check("par_bad_frame_err", fe_cnt - fe0, 1);
      check("par_bad_busy", busy, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rs232_rx_module.md
Name: rs232_rx_module

Overview:
- RS232 8N1 receiver; the receive-side counterpart of the existing TX_MODULE.
- Samples the asynchronous serial line, reassembles bytes LSB first, and queues them in a small first-word-fall-through FIFO.
- Will carry host tuning and control commands into the SDR, such as PLL counter writes, alongside the existing TX link.
- Sits on the 50 MHz system clock domain. Its input is a header pin, its output goes to the command parser.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD, truncated (434 at defaults). HALF = DIV/2, truncated (217).
- FIFO_DEPTH_LOG2, 4, FIFO depth = 2^FIFO_DEPTH_LOG2 entries (16).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx  in  1  raw serial input. Asynchronous; idle high.
- rd_req  in  1  pop the FIFO head this cycle.
- rx_data  out  8  FIFO head byte. Valid whenever rx_empty=0.
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- rx_count  out  FIFO_DEPTH_LOG2+1  number of bytes in the FIFO.
- frame_err  out  1  one-cycle pulse on a bad stop bit (or bad parity, see Optional Feature).
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- clear_err  in  1  synchronous clear of overflow.
- busy  out  1  high while the receiver FSM is not in IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - FSM in IDLE; synchronizer flops = 1.
  - FIFO pointers and count = 0.
  - Outputs: rx_data=0, rx_empty=1, rx_full=0, rx_count=0, frame_err=0, overflow=0, busy=0.
  - A reset mid-frame discards the partial byte. Bytes already in the FIFO are lost.
- Input synchronizer: two-flop synchronizer on rx, giving rx_s. All FSM decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0 -> START, baud counter=0.
  - START: count to HALF-1, then sample. rx_s=0 -> DATA, counter=0, bit index=0. rx_s=1 -> IDLE (glitch rejected, no flags).
  - DATA: count to DIV-1, then sample rx_s into shift[bit index] (LSB first). After bit 7 -> STOP.
  - STOP: count to DIV-1, then sample.
    - rx_s=1: byte goes to FIFO write, FSM -> IDLE.
    - rx_s=0: frame_err pulses for 1 cycle, byte discarded, FSM -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then -> IDLE. This prevents a break condition from being read as repeated 0x00 bytes.
- Write latency:
  - The FIFO write occurs on the cycle after the stop-bit sample.
  - rx_empty falls and rx_count increments on the following edge.
  - Total from the start-bit falling edge to rx_empty=0 is about 2 + HALF + 9*DIV + 2 cycles.
- FIFO:
  - Circular buffer with a registered rx_count.
  - First-word-fall-through: rx_data always shows the entry at the read pointer.
  - rd_req while rx_empty=1 is ignored; pointers do not move.
  - Write while full with no read: byte dropped, overflow set.
  - Write while full with rd_req in the same cycle: write accepted, count stays at full, no overflow.
  - Write and read on a non-empty FIFO in the same cycle: count unchanged.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2.
- overflow: sticky until clear_err=1. If clear_err and a new overflow event coincide, overflow stays set.

Optional Feature:
- Macro: RS232_RX_PARITY_EN.
- Defined:
  - An even-parity bit is expected after bit 7, sampled at DIV-1 in a PARITY state inserted between DATA and STOP.
  - On parity mismatch the byte is discarded and frame_err pulses at the stop-bit sample. The FSM then returns to IDLE if the stop bit is good, otherwise goes to WAIT_HIGH.
  - Frame is 11 bits.
- Undefined: 8N1 only, no PARITY state.

Test Plan:
- Byte reception: defaults, drive 0x21 as 8N1 at 434 clk/bit -> rx_empty falls after ~4130 cycles, rx_data=0x21, rx_count=1. Pulse rd_req -> rx_empty=1, rx_count=0.
- Glitch rejection: rx low for 100 cycles, then high -> FSM back in IDLE, busy falls, rx_empty stays 1, no frame_err.
- Framing error: send 0xA5 with stop bit=0, holding rx low for 2000 extra cycles -> exactly one frame_err pulse, FIFO empty, busy stays high until rx returns high. Then send 0x3C -> rx_data=0x3C.
- Overflow and ordering: send bytes 0x00..0x10 (17 bytes) with no reads -> rx_full=1, rx_count=16, overflow=1. Reading 16 times returns 0x00..0x0F in order. Pulse clear_err -> overflow=0.
- Reset mid-frame: assert reset_n=0 during bit 4 of 0x55, release, then send 0x7E -> only 0x7E appears, rx_count=1.
- Parity (RS232_RX_PARITY_EN defined): send 0x07 with parity=1 -> accepted. Send 0x07 with parity=0 -> frame_err pulse, byte discarded.
